scan_seq_ctrl: RTL and testbench

SCAN_SEQ_CTRL -- requirements
Module: scan_seq_ctrl

---
 rtl/scan_ctrl_pkg.sv | 25 ++
 rtl/scan_seq_ctrl_if.sv | 36 +++
 rtl/scan_misr.sv | 48 ++++
 rtl/scan_seq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_scan_seq_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan test sequencer: FSM state encoding, default CUT
// dimensions and the MISR feedback polynomial.
package scan_ctrl_pkg;

  localparam int unsigned DefChainLen = 5;
  localparam int unsigned DefPiW      = 18;
  localparam int unsigned DefPoW      = 19;

  // x^16 + x^12 + x^5 + 1, x^16 implied by the shift-out of bit 15
  localparam logic [15:0] MisrPoly = 16'h1021;

  typedef enum logic [2:0] {
    StIdle,
    StWaitPat,
    StShift,
    StCapture,
    StFlush,
    StDone
  } state_e;

  function automatic logic [15:0] misr_step(logic [15:0] cur, logic [15:0] din);
    return {cur[14:0], 1'b0} ^ (cur[15] ? MisrPoly : 16'h0000) ^ din;
  endfunction

endpackage

// File: rtl/scan_seq_ctrl_if.sv
// Pattern-delivery handshake between a pattern source (master) and the scan sequencer
// (slave); one transfer carries load state, primary inputs and both expected responses.
interface scan_seq_ctrl_if
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = DefChainLen,
  parameter int unsigned PI_W      = DefPiW,
  parameter int unsigned PO_W      = DefPoW
);

  logic                 pat_valid;
  logic                 pat_ready;
  logic [CHAIN_LEN-1:0] pat_si;
  logic [PI_W-1:0]      pat_pi;
  logic [PO_W-1:0]      pat_exp_po;
  logic [CHAIN_LEN-1:0] pat_exp_so;

  modport master (
    output pat_valid,
    output pat_si,
    output pat_pi,
    output pat_exp_po,
    output pat_exp_so,
    input  pat_ready
  );

  modport slave (
    input  pat_valid,
    input  pat_si,
    input  pat_pi,
    input  pat_exp_po,
    input  pat_exp_so,
    output pat_ready
  );

endinterface

// File: rtl/scan_misr.sv
// 16-bit multiple-input signature register: folds the captured primary outputs or a single
// scan-out bit into the running signature each enabled cycle.
module scan_misr
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DefPoW
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              clr,
  input  logic              po_en,
  input  logic [DATA_W-1:0] po,
  input  logic              so_en,
  input  logic              so,
  output logic [15:0]       signature
);

  localparam int unsigned Words = (DATA_W + 15) / 16;

  logic [Words*16-1:0] padded;
  logic [15:0]         folded;
  logic [15:0]         din;
  logic [15:0]         misr_q;

  // XOR-fold arbitrary-width primary outputs down to 16 bits
  always_comb begin
    padded              = '0;
    padded[DATA_W-1:0]  = po;
    folded              = '0;
    for (int w = 0; w < int'(Words); w++) begin
      folded = folded ^ padded[w*16 +: 16];
    end
    din = po_en ? folded : {15'h0000, so};
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      misr_q <= '0;
    end else if (clr) begin
      misr_q <= '0;
    end else if (po_en || so_en) begin
      misr_q <= misr_step(misr_q, din);
    end
  end

  assign signature = misr_q;

endmodule

// File: rtl/scan_seq_ctrl.sv
// Scan test sequencer: per pattern it shifts in load state, captures, and compares responses.
// Define SCAN_SEQ_CTRL_MISR_EN to build the response-compaction MISR behind signature.
module scan_seq_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = DefChainLen,
  parameter int unsigned PI_W      = DefPiW,
  parameter int unsigned PO_W      = DefPoW
) (
  input  logic            CK,
  input  logic            RST,
  input  logic            start,
  input  logic [15:0]     num_pat,
  scan_seq_ctrl_if.slave  pat,
  output logic            cut_se,
  output logic            cut_si,
  output logic [PI_W-1:0] cut_pi,
  input  logic            cut_so,
  input  logic [PO_W-1:0] cut_po,
  output logic            busy,
  output logic            done,
  output logic            fail,
  output logic [15:0]     fail_cnt,
  output logic [15:0]     signature
);

  localparam int unsigned CntW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CHAIN_LEN - 1);

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [15:0]          rem_q;
  logic [CHAIN_LEN-1:0] si_q;
  logic [CHAIN_LEN-1:0] exp_so_q;
  logic [CHAIN_LEN-1:0] prev_so_q;
  logic [PO_W-1:0]      exp_po_q;
  logic [PI_W-1:0]      pi_q;
  logic                 seen_q;
  logic                 cmp_en_q;
  logic [15:0]          fail_cnt_q;

  logic start_ok;
  logic xfer;
  logic so_cmp;
  logic po_cmp;
  logic so_bit_exp;
  logic mismatch;

  assign pat.pat_ready = (state_q == StWaitPat);
  assign start_ok      = (state_q == StIdle) && start;
  assign xfer          = pat.pat_ready && pat.pat_valid;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cut_se     = 1'b0;
    cut_si     = 1'b0;
    so_cmp     = 1'b0;
    so_bit_exp = 1'b0;
    po_cmp     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (num_pat == 16'd0) ? StDone : StWaitPat;
        end
      end
      StWaitPat: begin
        if (pat.pat_valid) begin
          state_d = StShift;
          cnt_d   = CntLast;
        end
      end
      StShift: begin
        // Unload of the previous pattern's capture overlaps this pattern's load
        cut_se     = 1'b1;
        cut_si     = si_q[cnt_q];
        so_cmp     = cmp_en_q;
        so_bit_exp = prev_so_q[cnt_q];
        if (cnt_q == '0) begin
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StCapture: begin
        po_cmp = 1'b1;
        if (rem_q != 16'd0) begin
          state_d = StWaitPat;
        end else begin
          state_d = StFlush;
          cnt_d   = CntLast;
        end
      end
      StFlush: begin
        cut_se     = 1'b1;
        so_cmp     = 1'b1;
        so_bit_exp = exp_so_q[cnt_q];
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign mismatch = (so_cmp && (cut_so != so_bit_exp)) || (po_cmp && (cut_po != exp_po_q));

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rem_q      <= '0;
      si_q       <= '0;
      exp_so_q   <= '0;
      prev_so_q  <= '0;
      exp_po_q   <= '0;
      pi_q       <= '0;
      seen_q     <= 1'b0;
      cmp_en_q   <= 1'b0;
      fail_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start_ok) begin
        rem_q      <= num_pat;
        seen_q     <= 1'b0;
        fail_cnt_q <= '0;
      end
      if (xfer) begin
        rem_q     <= rem_q - 16'd1;
        si_q      <= pat.pat_si;
        pi_q      <= pat.pat_pi;
        exp_po_q  <= pat.pat_exp_po;
        exp_so_q  <= pat.pat_exp_so;
        prev_so_q <= exp_so_q;
        // The first pattern of a session has no predecessor to unload
        cmp_en_q  <= seen_q;
        seen_q    <= 1'b1;
      end
      if (mismatch && (fail_cnt_q != 16'hFFFF)) begin
        fail_cnt_q <= fail_cnt_q + 16'd1;
      end
    end
  end

  assign cut_pi   = pi_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign fail_cnt = fail_cnt_q;
  assign fail     = (fail_cnt_q != 16'd0);

`ifdef SCAN_SEQ_CTRL_MISR_EN
  scan_misr #(
    .DATA_W (PO_W)
  ) u_misr (
    .CK        (CK),
    .RST       (RST),
    .clr       (start_ok),
    .po_en     (po_cmp),
    .po        (cut_po),
    .so_en     (so_cmp),
    .so        (cut_so),
    .signature (signature)
  );
`else
  assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Directed bench for scan_seq_ctrl: behavioural scan CUT, a scoreboard of expected cut_si bits
// and a scoreboard of per-session results checked whenever done pulses.
module tb_scan_seq_ctrl;
  import scan_ctrl_pkg::*;

  localparam int unsigned CL  = 5;
  localparam int unsigned PIW = 18;
  localparam int unsigned POW = 19;

  typedef struct packed {
    logic [15:0] fcnt;
    logic [15:0] sig;
    int          lat;
  } sess_t;

  logic            CK      = 1'b0;
  logic            RST     = 1'b1;
  logic            start   = 1'b0;
  logic [15:0]     num_pat = '0;
  logic            cut_se, cut_si, cut_so;
  logic [PIW-1:0]  cut_pi;
  logic [POW-1:0]  cut_po;
  logic            busy, done, fail;
  logic [15:0]     fail_cnt, signature;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_evt_cyc = 0;
  int dones = 0;
  logic done_prev = 1'b0;

  logic  si_exp_q[$];
  sess_t sess_q[$];

  logic [CL-1:0]  p_si[4];
  logic [PIW-1:0] p_pi[4];
  logic [POW-1:0] p_po_err[4];
  logic [CL-1:0]  p_so_err[4];
  int             p_stall[4];
  int             mid_chk_pat = -1;
  logic [15:0]    mid_chk_val = '0;

  scan_seq_ctrl_if #(.CHAIN_LEN(CL), .PI_W(PIW), .PO_W(POW)) pat_if ();

  scan_seq_ctrl #(
    .CHAIN_LEN (CL),
    .PI_W      (PIW),
    .PO_W      (POW)
  ) dut (
    .CK        (CK),
    .RST       (RST),
    .start     (start),
    .num_pat   (num_pat),
    .pat       (pat_if),
    .cut_se    (cut_se),
    .cut_si    (cut_si),
    .cut_pi    (cut_pi),
    .cut_so    (cut_so),
    .cut_po    (cut_po),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_cnt  (fail_cnt),
    .signature (signature)
  );

  always #5 CK = ~CK;
  always @(posedge CK) cyc <= cyc + 1;

  // Behavioural CUT: next state and outputs are simple functions of state and PIs
  function automatic logic [CL-1:0] cut_f(input logic [CL-1:0] s, input logic [PIW-1:0] pi);
    return {s[CL-2:0], s[CL-1]} ^ pi[CL-1:0];
  endfunction

  function automatic logic [POW-1:0] cut_g(input logic [CL-1:0] s, input logic [PIW-1:0] pi);
    return {pi ^ {{(PIW-CL){1'b0}}, s}, ^s};
  endfunction

  logic [CL-1:0] chain = '0;
  logic          se_prev = 1'b0;
  assign cut_so = chain[CL-1];
  assign cut_po = cut_g(chain, cut_pi);
  always @(posedge CK) begin
    se_prev <= cut_se;
    if (cut_se === 1'b1) chain <= {chain[CL-2:0], cut_si};
    else if (se_prev) chain <= cut_f(chain, cut_pi);
  end

  function automatic logic [15:0] fold16(input logic [POW-1:0] v);
    return v[15:0] ^ {13'h0000, v[18:16]};
  endfunction

  function automatic logic [15:0] m_step(input logic [15:0] s, input logic [15:0] d);
    logic [15:0] n;
    for (int i = 0; i < 16; i++) n[i] = ((i == 0) ? 1'b0 : s[i-1]) ^ d[i];
    n[0]  = n[0]  ^ s[15];
    n[5]  = n[5]  ^ s[15];
    n[12] = n[12] ^ s[15];
    return n;
  endfunction

  function automatic logic [15:0] gold_sig(input int n);
    logic [15:0]   s;
    logic [CL-1:0] so;
    s = 16'h0000;
    if (n == 0) return s;
    for (int p = 0; p < n; p++) begin
      if (p > 0) begin
        so = cut_f(p_si[p-1], p_pi[p-1]);
        for (int b = CL - 1; b >= 0; b--) s = m_step(s, {15'h0000, so[b]});
      end
      s = m_step(s, fold16(cut_g(p_si[p], p_pi[p])));
    end
    so = cut_f(p_si[n-1], p_pi[n-1]);
    for (int b = CL - 1; b >= 0; b--) s = m_step(s, {15'h0000, so[b]});
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  always @(negedge CK) begin : monitor
    logic  want_si;
    sess_t s;
    if (cut_se === 1'b1) begin
      chk("shift_expected", 32'(si_exp_q.size() != 0), 1);
      if (si_exp_q.size() != 0) begin
        want_si = si_exp_q.pop_front();
        chk("cut_si", cut_si, want_si);
      end
    end
    if (done_prev) begin
      chk("done_one_cycle", done, 0);
      chk("idle_after_done", busy, 0);
    end
    if (done === 1'b1) begin
      dones++;
      chk("done_expected", 32'(sess_q.size() != 0), 1);
      if (sess_q.size() != 0) begin
        s = sess_q.pop_front();
        chk("done_latency", cyc - last_evt_cyc, s.lat);
        chk("fail_cnt", fail_cnt, s.fcnt);
        chk("fail", fail, 32'(s.fcnt != 0));
        chk("signature", signature, s.sig);
        chk("busy_in_done", busy, 1);
      end
    end
    done_prev = (done === 1'b1);
  end

  task automatic clr_pats();
    for (int p = 0; p < 4; p++) begin
      p_po_err[p] = '0;
      p_so_err[p] = '0;
      p_stall[p]  = 0;
    end
  endtask

  task automatic send_pat(input int p, input bit last);
    pat_if.pat_valid = 1'b0;
    for (int i = 0; i < 64 && pat_if.pat_ready !== 1'b1; i++) @(negedge CK);
    chk("ready_seen", pat_if.pat_ready, 1);
    for (int i = 0; i < p_stall[p]; i++) begin
      start   = (i == 0);
      num_pat = '0;
      @(posedge CK);
      #1 start = 1'b0;
      chk("stall_ready", pat_if.pat_ready, 1);
      chk("stall_se", cut_se, 0);
    end
    for (int b = CL - 1; b >= 0; b--) si_exp_q.push_back(p_si[p][b]);
    if (last) for (int b = 0; b < int'(CL); b++) si_exp_q.push_back(1'b0);
    pat_if.pat_si     = p_si[p];
    pat_if.pat_pi     = p_pi[p];
    pat_if.pat_exp_po = cut_g(p_si[p], p_pi[p]) ^ p_po_err[p];
    pat_if.pat_exp_so = cut_f(p_si[p], p_pi[p]) ^ p_so_err[p];
    pat_if.pat_valid  = 1'b1;
    @(posedge CK);
    #1 pat_if.pat_valid = 1'b0;
    last_evt_cyc = cyc;
    chk("cut_pi_latched", cut_pi, p_pi[p]);
  endtask

  task automatic run_session(input int n);
    sess_t s;
    int    d0;
    int    exp_f;
    d0    = dones;
    exp_f = 0;
    for (int p = 0; p < n; p++) exp_f += int'(p_po_err[p] != 0) + $countones(p_so_err[p]);
    s.fcnt = 16'(exp_f);
`ifdef SCAN_SEQ_CTRL_MISR_EN
    s.sig  = gold_sig(n);
`else
    s.sig  = 16'h0000;
`endif
    s.lat  = (n == 0) ? 0 : 11;
    sess_q.push_back(s);
    start   = 1'b1;
    num_pat = 16'(n);
    @(posedge CK);
    #1 start = 1'b0;
    num_pat = '0;
    last_evt_cyc = cyc;
    chk("clear_on_start", fail_cnt, 0);
    chk("busy_after_start", busy, 1);
    if (n == 0) begin
      @(negedge CK);
      chk("zero_pat_ready", pat_if.pat_ready, 0);
      chk("zero_pat_se", cut_se, 0);
    end
    for (int p = 0; p < n; p++) begin
      send_pat(p, p == n - 1);
      if (p == mid_chk_pat) begin
        chk("fail_cnt_before_unload", fail_cnt, 0);
        repeat (CL) @(posedge CK);
        #1 chk("fail_cnt_after_unload", fail_cnt, mid_chk_val);
      end
    end
    for (int i = 0; i < 300 && dones == d0; i++) @(negedge CK);
    chk("done_seen", dones - d0, 1);
    @(negedge CK);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    pat_if.pat_valid  = 1'b0;
    pat_if.pat_si     = '0;
    pat_if.pat_pi     = '0;
    pat_if.pat_exp_po = '0;
    pat_if.pat_exp_so = '0;
    clr_pats();
    repeat (3) @(posedge CK);
    #1;
    chk("rst_ready", pat_if.pat_ready, 0);
    chk("rst_se", cut_se, 0);
    chk("rst_si", cut_si, 0);
    chk("rst_pi", cut_pi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    chk("rst_signature", signature, 0);
    RST = 1'b0;

    // Single clean pattern
    p_si[0] = 5'b10110; p_pi[0] = 18'h2A5C3;
    run_session(1);

    // Three patterns, PO mismatch on the second only; result held after done
    p_si[0] = 5'b00111; p_pi[0] = 18'h01234;
    p_si[1] = 5'b11001; p_pi[1] = 18'h3FF0A;
    p_si[2] = 5'b01010; p_pi[2] = 18'h15555;
    p_po_err[1] = 19'h00100;
    run_session(3);
    repeat (3) @(negedge CK);
    chk("fail_held", fail, 1);
    chk("fail_cnt_held", fail_cnt, 1);

    // Two scan-out bits of pattern 1 wrong, seen while pattern 2 shifts
    clr_pats();
    p_si[0] = 5'b11100; p_pi[0] = 18'h0ABCD;
    p_si[1] = 5'b00011; p_pi[1] = 18'h2468A;
    p_so_err[0] = 5'b01001;
    mid_chk_pat = 1; mid_chk_val = 16'd2;
    run_session(2);
    mid_chk_pat = -1;

    // Fixed four-pattern set with a stall (and an ignored start) before pattern 3
    clr_pats();
    p_si[0] = 5'b10011; p_pi[0] = 18'h1F00F;
    p_si[1] = 5'b01101; p_pi[1] = 18'h00F0F;
    p_si[2] = 5'b11111; p_pi[2] = 18'h3C3C3;
    p_si[3] = 5'b00001; p_pi[3] = 18'h12345;
    p_stall[2] = 3;
    run_session(4);

    // Empty session
    clr_pats();
    run_session(0);

    // Reset during the third shift cycle of pattern 1
    begin : abort_case
      int d0;
      d0 = dones;
      p_si[0] = 5'b01011; p_pi[0] = 18'h2F0F1;
      start = 1'b1; num_pat = 16'd2;
      @(posedge CK);
      #1 start = 1'b0; num_pat = '0;
      send_pat(0, 1'b0);
      repeat (2) @(posedge CK);
      #1 RST = 1'b1;
      @(posedge CK);
      #1 RST = 1'b0;
      si_exp_q.delete();
      chk("abort_ready", pat_if.pat_ready, 0);
      chk("abort_se", cut_se, 0);
      chk("abort_si", cut_si, 0);
      chk("abort_pi", cut_pi, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_fail_cnt", fail_cnt, 0);
      chk("abort_signature", signature, 0);
      repeat (20) @(negedge CK);
      chk("abort_no_done", dones - d0, 0);
    end

    // Recovery after abort
    p_si[0] = 5'b11010; p_pi[0] = 18'h0C0DE;
    run_session(1);

    chk("shift_queue_drained", si_exp_q.size(), 0);
    chk("session_queue_drained", sess_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
